fetch_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pc_register.sv | 32 +++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the instruction-fetch pipeline.
//   fetch_state_t   : fetch FSM states (RUN, HALTED)
//   NOP_INSTRUCTION : bubble instruction loaded into IF/ID (all zero)
//   HALT_OPCODE     : opcode (instruction[23:20]) that stops fetching
//   DEFAULT_PCSTEP  : PC increment per instruction
package pipeline_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   localparam logic [23:0] NOP_INSTRUCTION = 24'h000000;
   localparam logic [3:0]  HALT_OPCODE     = 4'hF;
   localparam int unsigned DEFAULT_PCSTEP  = 4;

endpackage : pipeline_pkg

// File: rtl/pc_register.sv
// pc_register: program-counter flop.
//   clock  in  rising-edge clock
//   reset  in  synchronous active-low reset, loads RESETPC
//   load   in  load target (redirect); wins over hold
//   hold   in  keep the current PC; otherwise PC advances by PCSTEP
//   target in  redirect address
//   pc     out current PC register
module pc_register import pipeline_pkg::*; #(
   parameter int unsigned       WIDTH   = 32,
   parameter int unsigned       PCSTEP  = DEFAULT_PCSTEP,
   parameter logic [WIDTH-1:0]  RESETPC = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             hold,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] pc
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc <= RESETPC;
      end else if (load) begin
         pc <= target;
      end else if (!hold) begin
         // Unsigned add, carry out of the top bit is dropped (wraps).
         pc <= pc + WIDTH'(PCSTEP);
      end
   end

endmodule : pc_register

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID pipeline register and halt FSM.
//   clock        in  rising-edge clock
//   reset        in  synchronous active-low reset
//   stall        in  hold PC and IF/ID (hazard logic)
//   branchTaken  in  redirect request from execute
//   branchTarget in  redirect PC
//   imemAddress  out fetch address (current PC register, combinational)
//   imemData     in  instruction-memory read data for imemAddress
//   instruction  out IF/ID instruction
//   PC           out IF/ID PC of instruction
//   valid        out IF/ID holds a real instruction (not a bubble)
//   halted       out FSM is in HALTED
module fetch_stage import pipeline_pkg::*; #(
   parameter int unsigned              WIDTH            = 32,
   parameter int unsigned              INSTRUCTIONWIDTH = 24,
   parameter int unsigned              OPCODEWIDTH      = 4,
   parameter int unsigned              PCSTEP           = DEFAULT_PCSTEP,
   parameter logic [WIDTH-1:0]         RESETPC          = '0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        branchTaken,
   input  logic [WIDTH-1:0]            branchTarget,
   output logic [WIDTH-1:0]            imemAddress,
   input  logic [INSTRUCTIONWIDTH-1:0] imemData,
   output logic [INSTRUCTIONWIDTH-1:0] instruction,
   output logic [WIDTH-1:0]            PC,
   output logic                        valid,
   output logic                        halted
);

   fetch_state_t                  state_q, state_d;
   logic [WIDTH-1:0]              pc_p0;
   logic [INSTRUCTIONWIDTH-1:0]   instr_p1, instr_d;
   logic [WIDTH-1:0]              pc_p1, pc_d;
   logic                          vld_p1, vld_d;
   logic                          pc_load, pc_hold;
   logic                          is_halt;

   assign is_halt = (imemData[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] ==
                     OPCODEWIDTH'(HALT_OPCODE));

   pc_register #(
      .WIDTH   (WIDTH),
      .PCSTEP  (PCSTEP),
      .RESETPC (RESETPC)
   ) u_pc (
      .clock  (clock),
      .reset  (reset),
      .load   (pc_load),
      .hold   (pc_hold),
      .target (branchTarget),
      .pc     (pc_p0)
   );

   // Stage 0 -> 1: next-state and IF/ID selection.
   always_comb begin
      state_d  = state_q;
      instr_d  = instr_p1;
      pc_d     = pc_p1;
      vld_d    = vld_p1;
      pc_load  = 1'b0;
      pc_hold  = 1'b1;
      if (branchTaken) begin
         // Redirect overrides stall and leaves one bubble behind.
         state_d = RUN;
         instr_d = INSTRUCTIONWIDTH'(NOP_INSTRUCTION);
         pc_d    = '0;
         vld_d   = 1'b0;
         pc_load = 1'b1;
      end else if (!stall) begin
         unique case (state_q)
            RUN: begin
               instr_d = imemData;
               pc_d    = pc_p0;
               vld_d   = 1'b1;
               // A halt is delivered to decode but the PC stops on it.
               if (is_halt) begin
                  state_d = HALTED;
               end else begin
                  pc_hold = 1'b0;
               end
            end
            HALTED: begin
               instr_d = INSTRUCTIONWIDTH'(NOP_INSTRUCTION);
               pc_d    = '0;
               vld_d   = 1'b0;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Stage 1: IF/ID register and FSM state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= RUN;
         instr_p1 <= '0;
         pc_p1    <= '0;
         vld_p1   <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_p1 <= instr_d;
         pc_p1    <= pc_d;
         vld_p1   <= vld_d;
      end
   end

   assign imemAddress = pc_p0;
   assign instruction = instr_p1;
   assign PC          = pc_p1;
   assign valid       = vld_p1;
   assign halted      = (state_q == HALTED);

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic [31:0] addr0, addr1;
   logic [23:0] imem0, imem1;
   logic [23:0] instr0, instr1;
   logic [31:0] pc0, pc1;
   logic        valid0, valid1, halted0, halted1;

   logic [23:0] mem [256];

   assign imem0 = mem[addr0[9:2]];
   assign imem1 = mem[addr1[9:2]];

   fetch_stage u_dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
      .imemAddress  (addr0),
      .imemData     (imem0),
      .instruction  (instr0),
      .PC           (pc0),
      .valid        (valid0),
      .halted       (halted0)
   );

   fetch_stage #(.RESETPC(32'hFFFF_FFFC)) u_dut_wrap (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
      .imemAddress  (addr1),
      .imemData     (imem1),
      .instruction  (instr1),
      .PC           (pc1),
      .valid        (valid1),
      .halted       (halted1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_fetch;   // address being fetched
   logic [23:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_halted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one clock edge with the given controls and advance the model.
   task automatic cycle(input logic rst_n, input logic st, input logic br, input logic [31:0] tgt);
      logic [23:0] word;
      reset        = rst_n;
      stall        = st;
      branchTaken  = br;
      branchTarget = tgt;
      word = mem[m_fetch[9:2]];
      if (!rst_n) begin
         m_fetch = 32'h0; m_instr = 24'h0; m_pc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      end else if (br) begin
         m_fetch = tgt; m_instr = 24'h0; m_pc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      end else if (st) begin
         // everything frozen
      end else if (!m_halted) begin
         m_instr = word; m_pc = m_fetch; m_valid = 1'b1;
         if (word[23:20] == 4'hF) m_halted = 1'b1;
         else m_fetch = m_fetch + 32'd4;
      end else begin
         m_instr = 24'h0; m_pc = 32'h0; m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      chk("imemAddress", addr0, m_fetch);
      chk("instruction", 32'(instr0), 32'(m_instr));
      chk("PC", pc0, m_pc);
      chk("valid", 32'(valid0), 32'(m_valid));
      chk("halted", 32'(halted0), 32'(m_halted));
   endtask

   typedef struct {
      logic        rst_n;
      logic        st;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic        e_valid;
      logic        e_halted;
   } vec_t;

   vec_t vecs [19];

   initial begin
      reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
      m_fetch = 32'h0; m_instr = 24'h0; m_pc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom) & 24'h7FFFFF;
      mem[4] = 24'hF00000;   // halt at 0x10

      //         rst st br tgt           addr          pc        v  h
      vecs[0]  = '{1'b0, 0, 0, 32'h0,  32'h00, 32'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 0, 0, 32'h0,  32'h04, 32'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 0, 0, 32'h0,  32'h08, 32'h04, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1, 0, 32'h0,  32'h08, 32'h04, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1, 0, 32'h0,  32'h08, 32'h04, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1, 0, 32'h0,  32'h08, 32'h04, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 0, 0, 32'h0,  32'h0C, 32'h08, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1, 1, 32'h40, 32'h40, 32'h00, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 0, 0, 32'h0,  32'h44, 32'h40, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 0, 1, 32'h10, 32'h10, 32'h00, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 0, 0, 32'h0,  32'h10, 32'h10, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 0, 0, 32'h0,  32'h10, 32'h00, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 0, 1, 32'h20, 32'h20, 32'h00, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 0, 0, 32'h0,  32'h24, 32'h20, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 0, 1, 32'h10, 32'h10, 32'h00, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 0, 0, 32'h0,  32'h10, 32'h10, 1'b1, 1'b1};
      vecs[16] = '{1'b1, 1, 0, 32'h0,  32'h10, 32'h10, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 1, 1, 32'h80, 32'h00, 32'h00, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 0, 0, 32'h0,  32'h04, 32'h00, 1'b1, 1'b0};

      for (int i = 0; i < 19; i++) begin
         cycle(vecs[i].rst_n, vecs[i].st, vecs[i].br, vecs[i].tgt);
         chk($sformatf("vec%0d addr", i), addr0, vecs[i].e_addr);
         chk($sformatf("vec%0d pc", i), pc0, vecs[i].e_pc);
         chk($sformatf("vec%0d valid", i), 32'(valid0), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d halted", i), 32'(halted0), 32'(vecs[i].e_halted));
         if (i == 0) chk("wrap reset addr", addr1, 32'hFFFF_FFFC);
         if (i == 1) chk("wrap next addr", addr1, 32'h0000_0000);
         if (i == 10) chk("halt instr", 32'(instr0), 32'h00F0_0000);
         if (i == 17) chk("reset instr", 32'(instr0), 32'h0);
      end

      // Hand sequence: fetch-to-decode latency and redirect bubble.
      cycle(1'b1, 1'b0, 1'b1, 32'h100);
      chk("redir bubble valid", 32'(valid0), 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("redir target pc", pc0, 32'h100);
      chk("redir target instr", 32'(instr0), 32'(mem[8'h40]));

      // Randomized run against the model, with occasional halt opcodes.
      for (int i = 0; i < 256; i++) begin
         mem[i] = 24'($urandom);
         if (mem[i][23:20] == 4'hF && ($urandom_range(0, 1) == 0)) mem[i][23] = 1'b0;
      end
      for (int n = 0; n < 400; n++) begin
         logic r, s, b;
         r = ($urandom_range(0, 31) != 0);
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 7) == 0);
         cycle(r, s, b, {22'h0, 8'($urandom_range(0, 255)), 2'b00});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_stage
